// File: rtl/mem_port_sequencer.sv
// Sequences the unified single-ported memory between the MEM stage and IF stage,
// then releases the pipeline stall for one clock per pipeline cycle.
module mem_port_sequencer #(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        IFReq,
   input  logic [31:0] IFAddr,
   output logic [31:0] IFInstr,
   input  logic        MEMMemRead,
   input  logic        MEMMemWrite,
   input  logic [31:0] MEMALUResult,
   input  logic [31:0] MEMRegData2,
   output logic [31:0] MEMReadData,
   output logic        PipeStall,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   input  logic        MemReady,
   output logic        BusError,
   output logic [31:0] StallCount
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MEM_ACC = 3'd1,
      S_IF_ACC  = 3'd2,
      S_GO      = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [31:0]      r_if_instr;
   logic [31:0]      r_mem_rdata;
   logic             r_bus_error;
   logic [31:0]      r_stall_cnt;
   logic             w_timeout;
   logic             w_enter_acc;

   assign w_timeout   = (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1));
   assign w_enter_acc = ((w_next == S_MEM_ACC) || (w_next == S_IF_ACC)) && (w_next != r_state);

   // Next-state and combinational memory/stall outputs
   always_comb begin
      w_next    = r_state;
      MemReq    = 1'b0;
      MemWe     = 1'b0;
      MemAddr   = 32'd0;
      MemWData  = 32'd0;
      PipeStall = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (MEMMemRead || MEMMemWrite) w_next = S_MEM_ACC;
            else if (IFReq)                w_next = S_IF_ACC;
            else                           w_next = S_GO;
         end
         S_MEM_ACC: begin
            MemReq   = 1'b1;
            MemWe    = MEMMemWrite;
            MemAddr  = MEMALUResult;
            MemWData = MEMRegData2;
            if (MemReady)       w_next = IFReq ? S_IF_ACC : S_GO;
            else if (w_timeout) w_next = S_ERR;
         end
         S_IF_ACC: begin
            MemReq  = 1'b1;
            MemAddr = IFAddr;
            if (MemReady)       w_next = S_GO;
            else if (w_timeout) w_next = S_ERR;
         end
         S_GO: begin
            PipeStall = 1'b0;
            w_next    = S_IDLE;
         end
         S_ERR:   w_next = S_ERR;
         default: w_next = S_IDLE;
      endcase
   end

   // State, wait counter, capture registers, error flag and stall counter
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_if_instr  <= 32'd0;
         r_mem_rdata <= 32'd0;
         r_bus_error <= 1'b0;
         r_stall_cnt <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_enter_acc)              r_wait_cnt <= '0;
         else if (MemReq && !MemReady) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         if ((r_state == S_MEM_ACC) && MemReady && !MEMMemWrite) r_mem_rdata <= MemRData;
         if ((r_state == S_IF_ACC) && MemReady)                  r_if_instr  <= MemRData;
         if (w_next == S_ERR) r_bus_error <= 1'b1;
         if (PipeStall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign IFInstr     = r_if_instr;
   assign MEMReadData = r_mem_rdata;
   assign BusError    = r_bus_error;
   assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed testbench for mem_port_sequencer: fetch-only, load+fetch, store,
// timeout, completion on the limit cycle and reset during an access.
module tb_mem_port_sequencer;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        IFReq;
   logic [31:0] IFAddr;
   logic [31:0] IFInstr;
   logic        MEMMemRead;
   logic        MEMMemWrite;
   logic [31:0] MEMALUResult;
   logic [31:0] MEMRegData2;
   logic [31:0] MEMReadData;
   logic        PipeStall;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        MemReady;
   logic        BusError;
   logic [31:0] StallCount;

   int checks = 0;
   int passed = 0;

   mem_port_sequencer #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .IFReq(IFReq), .IFAddr(IFAddr), .IFInstr(IFInstr),
      .MEMMemRead(MEMMemRead), .MEMMemWrite(MEMMemWrite),
      .MEMALUResult(MEMALUResult), .MEMRegData2(MEMRegData2), .MEMReadData(MEMReadData),
      .PipeStall(PipeStall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady),
      .BusError(BusError), .StallCount(StallCount)
   );

   always #5 Clk = ~Clk;

   // Advance one clock; inputs are driven and outputs sampled at the falling edge
   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      tick();
      tick();
      Rst_n = 1'b1;
      #1;
      checks++; if ({PipeStall, MemReq, MemWe} !== 3'b100) $display("FAIL reset_ctrl got %b want 100", {PipeStall, MemReq, MemWe}); else passed++;
      checks++; if ({MemAddr, MemWData} !== 64'd0) $display("FAIL reset_bus got %h want 0", {MemAddr, MemWData}); else passed++;
      checks++; if ({IFInstr, MEMReadData} !== 64'd0) $display("FAIL reset_capture got %h want 0", {IFInstr, MEMReadData}); else passed++;
      checks++; if ({BusError, StallCount} !== 33'd0) $display("FAIL reset_err_cnt got %h want 0", {BusError, StallCount}); else passed++;
   endtask

   task automatic test_fetch_only();
      IFReq = 1'b1; IFAddr = 32'h40; MemReady = 1'b1; MemRData = 32'h2010FFFF;
      #1;
      checks++; if ({PipeStall, MemReq} !== 2'b10) $display("FAIL f_idle got %b want 10", {PipeStall, MemReq}); else passed++;
      tick();
      checks++; if ({PipeStall, MemReq, MemWe} !== 3'b110) $display("FAIL f_acc_ctrl got %b want 110", {PipeStall, MemReq, MemWe}); else passed++;
      checks++; if (MemAddr !== 32'h40) $display("FAIL f_acc_addr got %h want 00000040", MemAddr); else passed++;
      tick();
      checks++; if ({PipeStall, MemReq} !== 2'b00) $display("FAIL f_go got %b want 00", {PipeStall, MemReq}); else passed++;
      checks++; if (IFInstr !== 32'h2010FFFF) $display("FAIL f_instr got %h want 2010ffff", IFInstr); else passed++;
      IFReq = 1'b0;
      tick();
      checks++; if (StallCount !== 32'd2) $display("FAIL f_stallcnt got %0d want 2", StallCount); else passed++;
   endtask

   task automatic test_load_fetch();
      MEMMemRead = 1'b1; MEMALUResult = 32'h100; IFReq = 1'b1; IFAddr = 32'h44; MemReady = 1'b0; MemRData = 32'h0;
      tick();
      checks++; if ({MemReq, MemWe, MemAddr} !== {2'b10, 32'h100}) $display("FAIL l_mem1 got %b/%h want 10/00000100", {MemReq, MemWe}, MemAddr); else passed++;
      tick();
      checks++; if ({PipeStall, MemReq, MemAddr} !== {2'b11, 32'h100}) $display("FAIL l_mem2 got %b/%h want 11/00000100", {PipeStall, MemReq}, MemAddr); else passed++;
      tick();
      MemReady = 1'b1; MemRData = 32'hDEADBEEF;
      #1;
      checks++; if (PipeStall !== 1'b1) $display("FAIL l_mem3_stall got %b want 1", PipeStall); else passed++;
      tick();
      MemRData = 32'h8C020004;
      #1;
      checks++; if ({MemReq, MemWe, MemAddr} !== {2'b10, 32'h44}) $display("FAIL l_if_addr got %b/%h want 10/00000044", {MemReq, MemWe}, MemAddr); else passed++;
      checks++; if (MEMReadData !== 32'hDEADBEEF) $display("FAIL l_rdata got %h want deadbeef", MEMReadData); else passed++;
      checks++; if (PipeStall !== 1'b1) $display("FAIL l_if_stall got %b want 1", PipeStall); else passed++;
      tick();
      checks++; if (PipeStall !== 1'b0) $display("FAIL l_go_cycle6 got %b want 0", PipeStall); else passed++;
      checks++; if (IFInstr !== 32'h8C020004) $display("FAIL l_instr got %h want 8c020004", IFInstr); else passed++;
      MEMMemRead = 1'b0; IFReq = 1'b0;
      tick();
   endtask

   task automatic test_store();
      MEMMemRead = 1'b1; MEMMemWrite = 1'b1; MEMALUResult = 32'h200; MEMRegData2 = 32'h12345678;
      IFReq = 1'b0; MemReady = 1'b1; MemRData = 32'hCAFEF00D;
      tick();
      checks++; if ({MemReq, MemWe} !== 2'b11) $display("FAIL s_ctrl got %b want 11", {MemReq, MemWe}); else passed++;
      checks++; if ({MemAddr, MemWData} !== {32'h200, 32'h12345678}) $display("FAIL s_bus got %h want 0000020012345678", {MemAddr, MemWData}); else passed++;
      tick();
      checks++; if (PipeStall !== 1'b0) $display("FAIL s_go got %b want 0", PipeStall); else passed++;
      checks++; if (MEMReadData !== 32'hDEADBEEF) $display("FAIL s_rdata_held got %h want deadbeef", MEMReadData); else passed++;
      MEMMemRead = 1'b0; MEMMemWrite = 1'b0;
      tick();
   endtask

   task automatic test_limit_completion();
      IFReq = 1'b1; IFAddr = 32'h80; MemReady = 1'b0; MemRData = 32'h55AA55AA;
      tick();
      tick();
      tick();
      tick();
      MemReady = 1'b1;
      #1;
      checks++; if ({MemReq, BusError} !== 2'b10) $display("FAIL lc_last got %b want 10", {MemReq, BusError}); else passed++;
      tick();
      checks++; if ({PipeStall, BusError} !== 2'b00) $display("FAIL lc_go got %b want 00", {PipeStall, BusError}); else passed++;
      checks++; if (IFInstr !== 32'h55AA55AA) $display("FAIL lc_instr got %h want 55aa55aa", IFInstr); else passed++;
      IFReq = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int stall_bad;
      IFReq = 1'b1; IFAddr = 32'h84; MemReady = 1'b0; MemRData = 32'h77777777;
      tick();
      tick();
      tick();
      tick();
      checks++; if ({MemReq, BusError} !== 2'b10) $display("FAIL to_4th got %b want 10", {MemReq, BusError}); else passed++;
      tick();
      checks++; if ({BusError, MemReq, PipeStall} !== 3'b101) $display("FAIL to_err got %b want 101", {BusError, MemReq, PipeStall}); else passed++;
      MemReady = 1'b1;
      stall_bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (PipeStall !== 1'b1 || MemReq !== 1'b0) stall_bad++;
      end
      checks++; if (stall_bad !== 0) $display("FAIL to_hold got %0d bad cycles want 0", stall_bad); else passed++;
      checks++; if ({BusError, IFInstr} !== {1'b1, 32'h55AA55AA}) $display("FAIL to_sticky got %b/%h want 1/55aa55aa", BusError, IFInstr); else passed++;
      IFReq = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      test_reset();
      MEMMemRead = 1'b1; MEMALUResult = 32'h300; IFReq = 1'b0; MemReady = 1'b1; MemRData = 32'h11112222;
      tick();
      tick();
      checks++; if ({PipeStall, MEMReadData} !== {1'b0, 32'h11112222}) $display("FAIL rm_load got %b/%h want 0/11112222", PipeStall, MEMReadData); else passed++;
      MemReady = 1'b0;
      tick();
      tick();
      checks++; if (MemReq !== 1'b1) $display("FAIL rm_in_acc got %b want 1", MemReq); else passed++;
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      #1;
      checks++; if ({PipeStall, MemReq, MemWe} !== 3'b100) $display("FAIL rm_ctrl got %b want 100", {PipeStall, MemReq, MemWe}); else passed++;
      checks++; if ({IFInstr, MEMReadData} !== 64'd0) $display("FAIL rm_capture got %h want 0", {IFInstr, MEMReadData}); else passed++;
      checks++; if ({BusError, StallCount} !== 33'd0) $display("FAIL rm_err_cnt got %h want 0", {BusError, StallCount}); else passed++;
      tick();
      checks++; if ({MemReq, MemAddr} !== {1'b1, 32'h300}) $display("FAIL rm_resume got %b/%h want 1/00000300", MemReq, MemAddr); else passed++;
      MEMMemRead = 1'b0;
   endtask

   initial begin
      Rst_n = 1'b0; IFReq = 1'b0; IFAddr = 32'd0; MEMMemRead = 1'b0; MEMMemWrite = 1'b0;
      MEMALUResult = 32'd0; MEMRegData2 = 32'd0; MemRData = 32'd0; MemReady = 1'b0;
      @(negedge Clk);
      test_reset();
      test_fetch_only();
      test_load_fetch();
      test_store();
      test_limit_completion();
      test_timeout();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
